demuxp_dist: RTL and testbench
==============================

// Module: demuxp_dist
// PURPOSE
//  Write-back distributor: inverse of the 4:1 register-field select mux. Takes one
//  WIDTH-bit value plus a 2-bit destination select and delivers it to one of four
//  output channels, or to all four in broadcast mode. Each channel has a one-entry
//  holding buffer with valid/ack handshake. Sits between the decode stage and the
//  register-index consumers.
// PARAMETERS
//  WIDTH   5  data width per channel (register index width)
//  CNT_W   8  width of the saturating accepted-word counter
// PORTS
//  clk        in   1        single clock; all state updates on rising edge
//  rst        in   1        synchronous, active-high reset
//  in_valid   in   1        producer offers in_data this cycle
//  in_ready   out  1        distributor accepts this cycle (combinational)
//  in_sel     in   2        destination: 0=a 1=b 2=c 3=d (ignored if in_bcast)
//  in_bcast   in   1        deliver in_data to all four channels
//  in_data    in   WIDTH    value to distribute
//  out_a..d   out  WIDTH    per-channel held data (four ports)
//  out_valid  out  4        bit i: channel i holds undelivered data (bit0=a)
//  out_ack    in   4        bit i: consumer i takes data this cycle
//  acc_cnt    out  CNT_W    number of accepted input words, saturating
// BEHAVIOUR
//  - Reset: out_valid=0, out_a..d=0, acc_cnt=0. Reset is synchronous only. Reset
//    mid-operation discards all held data; no ack is required afterwards.
//  - Channel i is free when !out_valid[i] || out_ack[i].
//  - in_ready:
//    - in_bcast=0: in_ready = free[in_sel].
//    - in_bcast=1: in_ready = AND of all four free bits.
//    - in_ready never depends on in_valid.
//  - Accept = in_valid && in_ready. On accept, each target channel loads in_data at
//    the edge. Its out_valid is 1 from the next cycle. Latency is 1 cycle.
//  - Hold: while out_valid[i]=1 and out_ack[i]=0, out_x[i] stays stable.
//  - Ack with valid: out_valid[i] clears next cycle unless the same channel is
//    reloaded that cycle.
//  - Simultaneous ack and accept on channel i: new data loads, out_valid[i] stays 1.
//    This gives full throughput of 1 word/cycle per channel.
//  - out_ack[i] while out_valid[i]=0 is ignored and is not an error.
//  - Non-target channels are unaffected by an accept.
//  - Data regs load only on accept. They keep the last value after ack, so there
//    is no clear-on-ack.
//  - acc_cnt increments by 1 per accept (a broadcast counts as 1). It saturates at
//    2^CNT_W-1 with no wrap.
//  - in_sel and in_bcast are sampled only with in_valid. With in_valid=0 there is
//    no state change except acks.
//  - Per-channel state machine EMPTY/FULL:
//    - EMPTY -> FULL on load.
//    - FULL -> EMPTY on ack without load.
//    - FULL -> FULL on ack with load, or on no ack.
// STRUCTURE
//  - Shared include (isa_defs.vh): CH_A=2'd0, CH_B=2'd1, CH_C=2'd2, CH_D=2'd3,
//    REG_IDX_W=5.
//  - Sub-module demux_slot (one-entry valid/ack buffer: clk, rst, load, d, ack,
//    q, valid, free), instantiated 4x.
//  - Top level holds: select decode to a 4-bit load mask, the ready reduction,
//    and the acc_cnt counter.
// TESTING
//  1. Reset, then in_sel=2, data=5'h13, valid 1 cycle -> next cycle out_valid=4'b0100,
//     out_c=5'h13, acc_cnt=1.
//  2. Channel b full, no ack; offer sel=1 -> in_ready=0 held, out_b unchanged. Then
//     assert ack[1] with a new offer 5'h07 -> accepted, out_b=5'h07, valid[1] stays 1.
//  3. in_bcast=1, data=5'h1F, channel d full -> in_ready=0. Ack d -> same cycle
//     in_ready=1, next cycle out_valid=4'hF, all outputs 5'h1F, acc_cnt +1 only.
//  4. Back-to-back stream to channel a for 10 cycles with ack[0] held 1 -> 10
//     accepts in 10 cycles, out_a follows input with 1-cycle lag.
//  5. ack[3] on empty channel d -> no change. Assert rst while channels a and c are
//     full -> next cycle out_valid=0, all data 0, acc_cnt=0.
//  6. CNT_W=4, 20 accepts -> acc_cnt stops at 15 with no wrap.

Source files
------------

// File: rtl/demuxp_dist_pkg.sv
// Shared definitions for the write-back distributor: channel codes, index width,
// per-slot state type and the select-to-mask decode.
package demuxp_dist_pkg;

  localparam logic [1:0]  CH_A      = 2'd0;
  localparam logic [1:0]  CH_B      = 2'd1;
  localparam logic [1:0]  CH_C      = 2'd2;
  localparam logic [1:0]  CH_D      = 2'd3;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned NUM_CH    = 4;

  typedef enum logic {
    SlotEmpty,
    SlotFull
  } slot_state_e;

  function automatic logic [NUM_CH-1:0] sel_to_mask(input logic [1:0] sel);
    logic [NUM_CH-1:0] mask;
    mask = '0;
    mask[sel] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry holding buffer with valid/ack handshake. Data is kept after ack; only a
// load replaces it.
module demux_slot
  import demuxp_dist_pkg::*;
#(
  parameter int unsigned WIDTH = REG_IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             ack,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  output logic             free
);

  slot_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (load) begin
      state_d = SlotFull;
      data_d  = d;
    end else if (state_q == SlotFull && ack) begin
      state_d = SlotEmpty;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SlotEmpty;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign valid = (state_q == SlotFull);
  // An ack in the current cycle frees the slot for a same-cycle reload.
  assign free  = (state_q == SlotEmpty) || ack;
  assign q     = data_q;

endmodule

// File: rtl/demuxp_dist.sv
// Write-back distributor: routes one value to one of four channels or broadcasts it
// to all four, with per-channel holding buffers and a saturating accept counter.
module demuxp_dist
  import demuxp_dist_pkg::*;
#(
  parameter int unsigned WIDTH = REG_IDX_W,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_sel,
  input  logic             in_bcast,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_c,
  output logic [WIDTH-1:0] out_d,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ack,
  output logic [CNT_W-1:0] acc_cnt
);

  logic [NUM_CH-1:0] free;
  logic [NUM_CH-1:0] load_mask;
  logic [NUM_CH-1:0] target_mask;
  logic [WIDTH-1:0]  slot_data [NUM_CH];
  logic              accept;
  logic [CNT_W-1:0]  acc_cnt_q, acc_cnt_d;

  always_comb begin
    target_mask = in_bcast ? {NUM_CH{1'b1}} : sel_to_mask(in_sel);
    // Ready depends only on slot state, acks, select and broadcast -- never on in_valid.
    in_ready    = &(free | ~target_mask);
    accept      = in_valid && in_ready;
    load_mask   = accept ? target_mask : '0;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
    demux_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk  (clk),
      .rst  (rst),
      .load (load_mask[i]),
      .d    (in_data),
      .ack  (out_ack[i]),
      .q    (slot_data[i]),
      .valid(out_valid[i]),
      .free (free[i])
    );
  end

  always_comb begin
    acc_cnt_d = acc_cnt_q;
    if (accept && (acc_cnt_q != {CNT_W{1'b1}})) begin
      acc_cnt_d = acc_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_cnt_q <= '0;
    end else begin
      acc_cnt_q <= acc_cnt_d;
    end
  end

  assign acc_cnt = acc_cnt_q;
  assign out_a   = slot_data[CH_A];
  assign out_b   = slot_data[CH_B];
  assign out_c   = slot_data[CH_C];
  assign out_d   = slot_data[CH_D];

endmodule

// File: tb/tb_demuxp_dist.sv
// Bench for demuxp_dist: a behavioural model checked every cycle against two DUTs
// (8-bit and 4-bit counters) driven by the same directed vectors.
module tb_demuxp_dist;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [1:0] in_sel;
  logic       in_bcast;
  logic [4:0] in_data;
  logic [3:0] out_ack;

  logic       in_ready, in_ready4;
  logic [4:0] out_a, out_b, out_c, out_d;
  logic [4:0] s_a, s_b, s_c, s_d;
  logic [3:0] out_valid, out_valid4;
  logic [7:0] acc_cnt;
  logic [3:0] acc_cnt4;

  int checks = 0;
  int errors = 0;

  // Model state
  bit   mv [4];
  logic [4:0] md [4];
  int   mcnt8, mcnt4;
  bit   chk_en = 1'b0;

  always #5 clk = ~clk;

  demuxp_dist #(.WIDTH(5), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
    .in_bcast(in_bcast), .in_data(in_data), .out_a(out_a), .out_b(out_b),
    .out_c(out_c), .out_d(out_d), .out_valid(out_valid), .out_ack(out_ack),
    .acc_cnt(acc_cnt)
  );

  demuxp_dist #(.WIDTH(5), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .in_sel(in_sel),
    .in_bcast(in_bcast), .in_data(in_data), .out_a(s_a), .out_b(s_b),
    .out_c(s_c), .out_d(s_d), .out_valid(out_valid4), .out_ack(out_ack),
    .acc_cnt(acc_cnt4)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_ready();
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if ((in_bcast || in_sel == 2'(i)) && mv[i] && !out_ack[i]) ok = 1'b0;
    end
    return ok;
  endfunction

  // Model update: what each channel must hold after this edge.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        mv[i] = 1'b0;
        md[i] = '0;
      end
      mcnt8 = 0;
      mcnt4 = 0;
    end else begin
      bit acc;
      acc = in_valid && model_ready();
      for (int i = 0; i < 4; i++) begin
        if (acc && (in_bcast || in_sel == 2'(i))) begin
          mv[i] = 1'b1;
          md[i] = in_data;
        end else if (out_ack[i]) begin
          mv[i] = 1'b0;
        end
      end
      if (acc) begin
        if (mcnt8 < 255) mcnt8++;
        if (mcnt4 < 15) mcnt4++;
      end
    end
  end

  // Compare process, mid low phase after inputs have settled.
  always @(negedge clk) begin
    #3;
    if (chk_en) begin
      chk("out_valid", int'(out_valid), int'({mv[3], mv[2], mv[1], mv[0]}));
      chk("out_a", int'(out_a), int'(md[0]));
      chk("out_b", int'(out_b), int'(md[1]));
      chk("out_c", int'(out_c), int'(md[2]));
      chk("out_d", int'(out_d), int'(md[3]));
      chk("acc_cnt", int'(acc_cnt), mcnt8);
      chk("acc_cnt4", int'(acc_cnt4), mcnt4);
      chk("in_ready", int'(in_ready), int'(model_ready()));
      chk("in_ready4", int'(in_ready4), int'(model_ready()));
      chk("out_valid4", int'(out_valid4), int'(out_valid));
    end
  end

  // Drive one cycle of inputs, then return at the compare point of that cycle.
  task automatic drive(input bit r, input bit v, input logic [1:0] s, input bit b,
                       input logic [4:0] d, input logic [3:0] a);
    @(negedge clk);
    #1;
    rst = r; in_valid = v; in_sel = s; in_bcast = b; in_data = d; out_ack = a;
    #2;
  endtask

  task automatic idle(input logic [3:0] a);
    drive(1'b0, 1'b0, 2'd0, 1'b0, 5'h00, a);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_bcast = 1'b0; in_data = '0;
    out_ack = '0;
    drive(1'b1, 1'b0, 2'd0, 1'b0, 5'h00, 4'h0);
    chk_en = 1'b1;
    idle(4'h0);
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset acc_cnt", int'(acc_cnt), 0);
    chk("reset out_d", int'(out_d), 0);

    // 1: single write to c
    drive(1'b0, 1'b1, 2'd2, 1'b0, 5'h13, 4'h0);
    idle(4'h0);
    chk("t1 out_valid", int'(out_valid), 'b0100);
    chk("t1 out_c", int'(out_c), 'h13);
    chk("t1 acc_cnt", int'(acc_cnt), 1);

    // 2: b full without ack blocks, ack with new offer reloads
    drive(1'b0, 1'b1, 2'd1, 1'b0, 5'h0A, 4'h0);
    drive(1'b0, 1'b1, 2'd1, 1'b0, 5'h0B, 4'h0);
    chk("t2 blocked ready", int'(in_ready), 0);
    chk("t2 hold b", int'(out_b), 'h0A);
    drive(1'b0, 1'b1, 2'd1, 1'b0, 5'h0B, 4'h0);
    chk("t2 hold b again", int'(out_b), 'h0A);
    drive(1'b0, 1'b1, 2'd1, 1'b0, 5'h07, 4'b0010);
    chk("t2 ack ready", int'(in_ready), 1);
    idle(4'h0);
    chk("t2 out_b", int'(out_b), 'h07);
    chk("t2 valid b", int'(out_valid[1]), 1);

    // 3: broadcast blocked by d until d is acked
    drive(1'b0, 1'b1, 2'd3, 1'b0, 5'h02, 4'h0);
    drive(1'b0, 1'b1, 2'd0, 1'b1, 5'h1F, 4'b0110);
    chk("t3 bcast blocked", int'(in_ready), 0);
    drive(1'b0, 1'b1, 2'd0, 1'b1, 5'h1F, 4'b1000);
    chk("t3 bcast ready", int'(in_ready), 1);
    idle(4'h0);
    chk("t3 out_valid", int'(out_valid), 'hF);
    chk("t3 all data", int'({out_a, out_b, out_c, out_d}), int'({4{5'h1F}}));
    chk("t3 acc_cnt", int'(acc_cnt), 5);
    idle(4'hF);

    // 4: full-rate stream to a
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, 2'd0, 1'b0, 5'(i + 1), 4'b0001);
      chk("t4 ready", int'(in_ready), 1);
      if (i > 0) chk("t4 lag", int'(out_a), i);
    end
    idle(4'b0001);
    chk("t4 last a", int'(out_a), 10);
    chk("t4 acc_cnt", int'(acc_cnt), 15);

    // 5: stray ack on empty d, then reset with a and c full
    drive(1'b0, 1'b0, 2'd0, 1'b0, 5'h00, 4'b1000);
    idle(4'h0);
    chk("t5 stray ack", int'(out_valid), 0);
    drive(1'b0, 1'b1, 2'd0, 1'b0, 5'h03, 4'h0);
    drive(1'b0, 1'b1, 2'd2, 1'b0, 5'h04, 4'h0);
    idle(4'h0);
    chk("t5 a,c full", int'(out_valid), 'b0101);
    chk("t5 cnt4 sat", int'(acc_cnt4), 15);
    drive(1'b1, 1'b1, 2'd1, 1'b0, 5'h09, 4'h0);
    idle(4'h0);
    chk("t5 rst valid", int'(out_valid), 0);
    chk("t5 rst data", int'({out_a, out_b, out_c, out_d}), 0);
    chk("t5 rst acc", int'(acc_cnt), 0);

    // 6: 20 accepts, 4-bit counter saturates
    for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, 2'd0, 1'b0, 5'(i), 4'b0001);
    idle(4'b0001);
    chk("t6 acc_cnt4", int'(acc_cnt4), 15);
    chk("t6 acc_cnt", int'(acc_cnt), 20);
    idle(4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
